btn_debounce2: RTL and testbench

- Two-channel input conditioner that sits directly upstream of the 2-input gate blocks.
- Takes raw, asynchronous push-button/switch levels, synchronises them to clk and debounces them.
- Drives clean levels onto the gate's a/b inputs, plus single-cycle edge pulses for LEDs and counters.

---
 rtl/btn_debounce2.sv | 138 +++++++++++++
 tb/tb_btn_debounce2.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/btn_debounce2.sv
// btn_debounce2: two-channel push-button conditioner.
// Each raw, asynchronous button level is synchronised to clk and debounced. The result is a
// clean level plus registered single-cycle rise/fall pulses. The two channels are fully
// independent and share no state.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept a new level (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//   SYNC_STAGES      flops per synchroniser chain (>= 2)
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_a, btn_b   raw button levels
//   a, b           debounced levels
//   a_rise/a_fall  one-cycle pulses on a 0->1 / 1->0
//   b_rise/b_fall  one-cycle pulses on b 0->1 / 1->0
module btn_debounce2 #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a,
    input  logic btn_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLow,
        StToHigh,
        StHigh,
        StToLow
    } state_e;

    logic [1:0] w_raw;
    logic [1:0] w_lvl;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_raw = {btn_b, btn_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        state_e                 r_state;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_lvl;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_s;

        // Last synchroniser stage is the only sample the FSM ever looks at.
        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync  <= '0;
                r_state <= StLow;
                r_cnt   <= '0;
                r_lvl   <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                case (r_state)
                    StLow: begin
                        if (w_s) begin
                            r_state <= StToHigh;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    StToHigh: begin
                        if (!w_s) begin
                            // Bounce or glitch: drop all progress.
                            r_state <= StLow;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= StHigh;
                            r_cnt   <= '0;
                            r_lvl   <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    StHigh: begin
                        if (!w_s) begin
                            r_state <= StToLow;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    StToLow: begin
                        if (w_s) begin
                            r_state <= StHigh;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= StLow;
                            r_cnt   <= '0;
                            r_lvl   <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= StLow;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_lvl[gi]  = r_lvl;
        assign w_rise[gi] = r_rise;
        assign w_fall[gi] = r_fall;
    end

    assign a      = w_lvl[0];
    assign b      = w_lvl[1];
    assign a_rise = w_rise[0];
    assign a_fall = w_fall[0];
    assign b_rise = w_rise[1];
    assign b_fall = w_fall[1];

endmodule

// File: tb/tb_btn_debounce2.sv
// Directed bench for btn_debounce2 with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Outputs are packed as {a, b, a_rise, a_fall, b_rise, b_fall}; a clean level change is
// expected on edge LAT (=6) counted from the first edge that samples the new raw level.
module tb_btn_debounce2;

    localparam int LAT = 6;

    logic clk;
    logic rst_n;
    logic btn_a;
    logic btn_b;
    logic a;
    logic b;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;
    logic [5:0] w_outs;

    int n_cmp;
    int n_err;

    btn_debounce2 #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .SYNC_STAGES    (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_a (btn_a),
        .btn_b (btn_b),
        .a     (a),
        .b     (b),
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
    );

    assign w_outs = {a, b, a_rise, a_fall, b_rise, b_fall};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges after an input change and compare against the expected debounced response.
    task automatic settle(input string tag, input int n, input logic old_a, input logic new_a,
                          input logic old_b, input logic new_b);
        logic la, lb, ra, fa, rb, fb;
        for (int e = 1; e <= n; e++) begin
            tick();
            la = (e >= LAT) ? new_a : old_a;
            lb = (e >= LAT) ? new_b : old_b;
            ra = (e == LAT) && new_a && !old_a;
            fa = (e == LAT) && !new_a && old_a;
            rb = (e == LAT) && new_b && !old_b;
            fb = (e == LAT) && !new_b && old_b;
            check_eq($sformatf("%s_e%0d", tag, e), w_outs, {la, lb, ra, fa, rb, fb});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        btn_a = 1'b1;
        btn_b = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // 1: reset held with buttons high
        #2 check_eq("rst_async", w_outs, 6'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq($sformatf("rst_hold%0d", i), w_outs, 6'b0);
        end
        rst_n = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        settle("idle", 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: channel A press
        btn_a = 1'b1;
        settle("press_a", 20, 1'b0, 1'b1, 1'b0, 1'b0);

        // 5: channel A release
        btn_a = 1'b0;
        settle("release_a", 10, 1'b1, 1'b0, 1'b0, 1'b0);

        // 3: three-cycle glitch is rejected
        btn_a = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) btn_a = 1'b0;
            check_eq($sformatf("glitch_e%0d", e), w_outs, 6'b0);
        end

        // 4: bouncing for 12 cycles, then held high
        for (int c = 0; c < 12; c++) begin
            btn_a = ((c / 2) % 2 == 0);
            tick();
            check_eq($sformatf("bounce_c%0d", c), w_outs, 6'b0);
        end
        btn_a = 1'b1;
        settle("bounce_hold", 10, 1'b0, 1'b1, 1'b0, 1'b0);
        btn_a = 1'b0;
        settle("bounce_rel", 10, 1'b1, 1'b0, 1'b0, 1'b0);

        // 6: both channels together
        btn_a = 1'b1;
        btn_b = 1'b1;
        settle("both", 10, 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous clear while outputs are high
        #2 rst_n = 1'b0;
        btn_a = 1'b0;
        btn_b = 1'b0;
        #1 check_eq("rst_mid_high", w_outs, 6'b0);
        tick();
        check_eq("rst_mid_hold", w_outs, 6'b0);
        rst_n = 1'b1;
        settle("post_rst", 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Repeat with reset arriving mid-debounce at edge 3
        btn_a = 1'b1;
        btn_b = 1'b1;
        settle("both_rst", 3, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        btn_a = 1'b0;
        btn_b = 1'b0;
        #1 check_eq("rst_e3", w_outs, 6'b0);
        tick();
        check_eq("rst_e3_hold", w_outs, 6'b0);
        rst_n = 1'b1;
        settle("after_e3", 10, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
